// File: rtl/apb_arb_pkg.sv
// Shared types and width helpers for the APB requester arbiter.
// The FSM state encoding lives here so the arbiter slice and its top agree on it.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  // Index/counter width with a floor of one bit, so degenerate sizes still elaborate.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin priority encoder: searches last+1, last+2, ... modulo NUM_REQ.
// Purely combinational; the owning FSM holds the last-grant pointer register.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int GW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last,
  output logic [GW-1:0]      gnt_idx,
  output logic               gnt_vld
);

  // Walk from farthest to nearest so the nearest set bit after 'last' wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_REQ]) begin
        gnt_idx = GW'((int'(last) + k) % NUM_REQ);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_requester_arbiter.sv
// Shares one APB completer between NUM_REQ requesters, one full transfer per grant.
// Latency: grant sampled in IDLE, SETUP +1, ACCESS +2, req_pready one cycle after m_pready.
module apb_requester_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  localparam int GW = idx_width(NUM_REQ),
  localparam int WW = idx_width(TIMEOUT + 1),
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic [NUM_REQ-1:0]            req_psel,
  input  logic [NUM_REQ-1:0]            req_pwrite,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_paddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_pwdata,
  input  logic [NUM_REQ*SW-1:0]         req_pstrb,
  output logic [NUM_REQ-1:0]            req_pready,
  output logic [DATA_WIDTH-1:0]         req_prdata,
  output logic [NUM_REQ-1:0]            req_pslverr,
  output logic                          m_psel,
  output logic                          m_penable,
  output logic                          m_pwrite,
  output logic [ADDR_WIDTH-1:0]         m_paddr,
  output logic [DATA_WIDTH-1:0]         m_pwdata,
  output logic [SW-1:0]                 m_pstrb,
  input  logic                          m_pready,
  input  logic [DATA_WIDTH-1:0]         m_prdata,
  input  logic                          m_pslverr,
  output logic [GW-1:0]                 grant_id,
  output logic                          timeout_stb
);

  typedef struct packed {
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [SW-1:0]         pstrb;
  } cmd_t;

  arb_state_e            state_q, state_d;
  cmd_t                  cmd_q;
  logic [GW-1:0]         last_q, grant_q, gnt_idx;
  logic                  gnt_vld;
  logic [WW-1:0]         wdog_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  grant, rsp_cap, wd_fire;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_psel),
    .last    (last_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    rsp_cap = 1'b0;
    wd_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          grant   = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (m_pready) begin
          rsp_cap = 1'b1;
          state_d = DONE;
        end else if (TIMEOUT != 0 && wdog_q == WW'(TIMEOUT - 1)) begin
          wd_fire = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cmd_q   <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      wdog_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant) begin
        cmd_q.pwrite <= req_pwrite[gnt_idx];
        cmd_q.paddr  <= req_paddr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_q.pwdata <= req_pwdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        cmd_q.pstrb  <= req_pstrb[gnt_idx*SW +: SW];
        grant_q      <= gnt_idx;
        last_q       <= gnt_idx;
      end
      // Counts ACCESS cycles only, saturating; any other state clears it.
      if (state_q == ACCESS) begin
        if (wdog_q != '1) wdog_q <= wdog_q + WW'(1);
      end else begin
        wdog_q <= '0;
      end
      if (rsp_cap) begin
        rdata_q <= m_prdata;
        err_q   <= m_pslverr;
      end else if (wd_fire) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign m_psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign m_penable   = (state_q == ACCESS);
  assign m_pwrite    = cmd_q.pwrite;
  assign m_paddr     = cmd_q.paddr;
  assign m_pwdata    = cmd_q.pwdata;
  assign m_pstrb     = cmd_q.pstrb;
  assign grant_id    = grant_q;
  assign req_prdata  = rdata_q;
  assign timeout_stb = wd_fire;

  always_comb begin
    req_pready  = '0;
    req_pslverr = '0;
    if (state_q == DONE) begin
      req_pready[grant_q]  = 1'b1;
      req_pslverr[grant_q] = err_q;
    end
  end

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Directed bench for apb_requester_arbiter: completer responses driven per transfer,
// requester completions checked against a queue of expected results.
module tb_apb_requester_arbiter;

  localparam int NR = 2;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             pclk = 1'b0;
  logic             preset_n;
  logic [NR-1:0]    req_psel, req_pwrite;
  logic [NR*AW-1:0] req_paddr;
  logic [NR*DW-1:0] req_pwdata;
  logic [NR*4-1:0]  req_pstrb;
  logic [NR-1:0]    req_pready, req_pslverr;
  logic [DW-1:0]    req_prdata;
  logic             m_psel, m_penable, m_pwrite;
  logic [AW-1:0]    m_paddr;
  logic [DW-1:0]    m_pwdata;
  logic [3:0]       m_pstrb;
  logic             m_pready, m_pslverr;
  logic [DW-1:0]    m_prdata;
  logic [0:0]       grant_id;
  logic             timeout_stb;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  apb_requester_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_psel(req_psel), .req_pwrite(req_pwrite), .req_paddr(req_paddr),
    .req_pwdata(req_pwdata), .req_pstrb(req_pstrb),
    .req_pready(req_pready), .req_prdata(req_prdata), .req_pslverr(req_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .grant_id(grant_id), .timeout_stb(timeout_stb)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic wr, input logic [23:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    req_pwrite[id]           = wr;
    req_paddr[id*AW +: AW]   = addr;
    req_pwdata[id*DW +: DW]  = wdata;
    req_pstrb[id*4 +: 4]     = strb;
  endtask

  task automatic push_exp(input int id, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.id = id; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  // Plays the completer for one granted transfer and retires one expected result.
  task automatic serve(input int id, input logic [23:0] addr, input logic wr,
                       input int waits, input logic [31:0] rdata, input logic err,
                       input logic hang, input logic [1:0] drop);
    int          n;
    int          k;
    exp_t        e;
    logic [23:0] saved;
    n = 0;
    @(negedge pclk);
    while (!(m_psel && !m_penable) && n < 20) begin
      @(negedge pclk);
      n++;
    end
    chk("setup_lat", n, 0);
    chk("grant_id", grant_id, id);
    chk("setup_paddr", m_paddr, addr);
    chk("setup_pwrite", m_pwrite, wr);
    if (wr) begin
      chk("setup_pwdata", m_pwdata, req_pwdata[id*DW +: DW]);
      chk("setup_pstrb", m_pstrb, req_pstrb[id*4 +: 4]);
    end
    saved    = req_paddr[id*AW +: AW];
    m_prdata = hang ? 32'hFFFF_FFFF : 32'h0;
    for (k = 0; k < 64; k++) begin
      @(negedge pclk);
      if (k == 0) req_paddr[id*AW +: AW] = ~saved;
      chk("access_phase", {m_psel, m_penable}, 2'b11);
      chk("access_paddr", m_paddr, addr);
      chk("timeout_stb", timeout_stb, 64'(hang && (k == TO - 1)));
      if (!hang && k == waits) begin
        m_pready  = 1'b1;
        m_prdata  = rdata;
        m_pslverr = err;
        break;
      end
      if (hang && k == TO - 1) break;
    end
    chk("access_bound", 64'(k < 64), 1);
    @(negedge pclk);
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
    m_prdata  = 32'h0;
    chk("done_bus_idle", {m_psel, m_penable}, 0);
    if (sb.size() == 0) begin
      chk("sb_underflow", req_pready, 0);
    end else begin
      e = sb.pop_front();
      chk("req_pready", req_pready, 64'(1) << e.id);
      chk("req_pslverr", req_pslverr, 64'(e.err) << e.id);
      chk("req_prdata", req_prdata, e.rdata);
    end
    req_paddr[id*AW +: AW] = saved;
    req_psel = req_psel & ~drop;
    @(negedge pclk);
    chk("idle_gap", {m_psel, req_pready}, 0);
  endtask

  initial begin
    preset_n   = 1'b0;
    req_psel   = '0;
    req_pwrite = '0;
    req_paddr  = '0;
    req_pwdata = '0;
    req_pstrb  = '0;
    m_pready   = 1'b0;
    m_prdata   = '0;
    m_pslverr  = 1'b0;

    repeat (3) @(negedge pclk);
    chk("rst_psel", {m_psel, m_penable}, 0);
    chk("rst_pready", req_pready, 0);
    chk("rst_pslverr", req_pslverr, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_prdata", req_prdata, 0);
    chk("rst_paddr", m_paddr, 0);
    chk("rst_timeout", timeout_stb, 0);
    preset_n = 1'b1;
    @(negedge pclk);
    chk("idle_no_req", m_psel, 0);

    // Single zero-wait write from requester 0.
    set_req(0, 1'b1, 24'h000104, 32'hDEADBEEF, 4'hF);
    req_psel = 2'b01;
    push_exp(0, 32'h0, 1'b0);
    serve(0, 24'h000104, 1'b1, 0, 32'h0, 1'b0, 1'b0, 2'b01);

    // Read with three wait states from requester 1.
    set_req(1, 1'b0, 24'h000200, 32'h0, 4'h0);
    req_psel = 2'b10;
    push_exp(1, 32'h12345678, 1'b0);
    serve(1, 24'h000200, 1'b0, 3, 32'h12345678, 1'b0, 1'b0, 2'b10);

    // Both requesting continuously: strict alternation starting after last grant (1).
    set_req(0, 1'b1, 24'h000010, 32'hA5A50000, 4'hF);
    set_req(1, 1'b1, 24'h000020, 32'h5A5A0001, 4'h3);
    req_psel = 2'b11;
    push_exp(0, 32'h0, 1'b0);
    push_exp(1, 32'h0, 1'b0);
    push_exp(0, 32'h0, 1'b0);
    push_exp(1, 32'h0, 1'b0);
    serve(0, 24'h000010, 1'b1, 0, 32'h0, 1'b0, 1'b0, 2'b00);
    serve(1, 24'h000020, 1'b1, 1, 32'h0, 1'b0, 1'b0, 2'b00);
    serve(0, 24'h000010, 1'b1, 2, 32'h0, 1'b0, 1'b0, 2'b00);
    serve(1, 24'h000020, 1'b1, 0, 32'h0, 1'b0, 1'b0, 2'b11);

    // Hung completer: watchdog errors requester 0, then pending requester 1 proceeds.
    set_req(0, 1'b0, 24'h000300, 32'h0, 4'h0);
    set_req(1, 1'b0, 24'h000304, 32'h0, 4'h0);
    req_psel = 2'b11;
    push_exp(0, 32'h0, 1'b1);
    push_exp(1, 32'hCAFEF00D, 1'b0);
    serve(0, 24'h000300, 1'b0, 0, 32'h0, 1'b0, 1'b1, 2'b01);
    serve(1, 24'h000304, 1'b0, 1, 32'hCAFEF00D, 1'b0, 1'b0, 2'b10);

    // Completer error on a write passes straight through.
    set_req(0, 1'b1, 24'h000500, 32'h00000001, 4'hF);
    req_psel = 2'b01;
    push_exp(0, 32'h0, 1'b1);
    serve(0, 24'h000500, 1'b1, 0, 32'h0, 1'b1, 1'b0, 2'b01);

    // Reset during a wait-stated read from requester 0 (last grant is 0).
    set_req(0, 1'b0, 24'h000600, 32'h0, 4'h0);
    req_psel = 2'b01;
    @(negedge pclk);
    chk("rm_setup", {m_psel, m_penable}, 2'b10);
    @(negedge pclk);
    chk("rm_access1", {m_psel, m_penable}, 2'b11);
    @(negedge pclk);
    chk("rm_access2", {m_psel, m_penable}, 2'b11);
    #2 preset_n = 1'b0;
    #1;
    chk("rm_async_psel", {m_psel, m_penable}, 0);
    chk("rm_async_paddr", m_paddr, 0);
    chk("rm_async_pready", req_pready, 0);
    chk("rm_async_grant", grant_id, 0);
    set_req(1, 1'b0, 24'h000604, 32'h0, 4'h0);
    req_psel = 2'b11;
    @(negedge pclk);
    chk("rm_hold_pready", req_pready, 0);
    @(negedge pclk);
    chk("rm_hold_psel", m_psel, 0);
    preset_n = 1'b1;
    push_exp(0, 32'h55AA55AA, 1'b0);
    push_exp(1, 32'h0F0F0F0F, 1'b0);
    serve(0, 24'h000600, 1'b0, 0, 32'h55AA55AA, 1'b0, 1'b0, 2'b01);
    serve(1, 24'h000604, 1'b0, 2, 32'h0F0F0F0F, 1'b0, 1'b0, 2'b10);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
